aes_round_sequencer: RTL
========================

// Module: aes_round_sequencer
// PURPOSE
//  Iterative AES round controller, the parametrised successor to the fixed AES-128 core wrapper.
//  Supports 128/192/256-bit keys and encrypt/decrypt, with a load/busy/done handshake.
//  Owns the state register, round counter and Rcon generator; drives an external round datapath via valid/ack.
//  Sits between the bus-facing wrapper and the aes round/key-schedule datapath.
// PARAMETERS
//  KEY_BITS  128  key length; legal values 128|192|256; NR = KEY_BITS/32 + 6 (10/12/14)
//  DATA_W    128  block width; fixed at 128, any other value is a $error at elaboration
// PORTS
//  clk           in   1         rising-edge clock
//  rst_n         in   1         asynchronous active-low reset
//  load_i        in   1         start request; accepted only when busy_o==0
//  dec_i         in   1         sampled with load_i: 0=encrypt, 1=decrypt
//  data_i        in   DATA_W    input block, sampled with load_i
//  key_i         in   KEY_BITS  cipher key, sampled with load_i
//  rnd_go_o      out  1         round request to datapath; held until rnd_ack_i
//  rnd_ack_i     in   1         datapath accepts round; rnd_result_i valid in same cycle
//  rnd_state_o   out  DATA_W    current state register presented to datapath
//  rnd_key_o     out  KEY_BITS  captured key (datapath expands it)
//  round_o       out  4         round index 0..NR (counts down when decrypting)
//  rcon_o        out  8         round constant for current round; 0x00 in round 0
//  first_round_o out  1         high during round 0 (initial AddRoundKey)
//  final_round_o out  1         high during last round (no MixColumns)
//  dec_o         out  1         captured mode
//  rnd_result_i  in   DATA_W    datapath result for current round
//  data_o        out  DATA_W    result block; holds until next accepted load
//  busy_o        out  1         high from the cycle after load acceptance until done
//  done_o        out  1         one-cycle pulse when data_o updates
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 (data_o, rnd_state_o, rnd_key_o zero; round_o 0; rcon_o 0x00).
//  FSM IDLE -> RUN (load_i & !busy_o) -> DONE (final round acked) -> IDLE (next cycle).
//  Load: captures data_i->state, key_i, dec_i; busy_o=1 from next cycle; load_i while busy is ignored.
//  RUN: rnd_go_o=1 continuously; on rnd_go_o & rnd_ack_i: state<=rnd_result_i, counter advances.
//  Round seq enc: round_o 0,1..NR; dec: NR..0 reported via round_o, first/final by step count.
//  first_round_o at step 0, final_round_o at step NR, for both modes; never both high together.
//  Rcon enc: step1=0x01, then xtime (x<<1 ^ (x[7]?0x1B:0)) per step.
//  Rcon dec: step1=Rcon[NR] (0x36/0xD8/0x4D), then inverse xtime: x[0] ? ((x^0x1B)>>1)|0x80 : x>>1.
//  Rcon is 0x00 at step 0; it advances only on ack, never on a stalled cycle.
//  DONE: data_o<=result of final round, done_o=1 one cycle, busy_o drops same edge DONE->IDLE.
//  Latency with rnd_ack_i tied 1: load at edge k; done_o high in cycle k+NR+2; stalls add 1:1.
//  load_i in the done_o cycle is ignored (busy still 1); accepted the following cycle.
//  Async reset mid-operation: immediate return to IDLE, done_o never pulses, data_o cleared.
//  rnd_ack_i outside RUN is ignored.
// CONFIGURATION
//  AES_SEQ_ABORT_EN defined: adds input abort_i (1 bit).
//   abort_i in RUN -> IDLE next edge; busy_o=0, no done_o, data_o keeps its previous value.
//   abort_i in IDLE is ignored; abort_i and load_i together in IDLE -> load is accepted.
//  Not defined: no abort_i port; a started operation always completes.
// TESTING
//  (loopback datapath model; rnd_result_i = rnd_state_o ^ {16{rcon_o}} unless noted)
//  T1 KEY_BITS=128 enc, ack=1, load data=0: round_o 0..10; rcon 00,01,02,04,08,10,20,40,80,1B,36; done at k+12.
//  T2 KEY_BITS=128 dec: round_o 10..0; rcon 00,36,1B,80,40,20,10,08,04,02,01; final_round_o at step 10 only.
//  T3 KEY_BITS=256 enc, ack random 50%: 15 acked rounds; rcon step14=0x4D; done after last ack +1; data_o matches model.
//  T4 load_i pulsed at step 3 with different data -> ignored; data_o equals first block's result.
//  T5 rst_n low at step 5 -> busy_o/done_o/data_o=0 immediately; new load runs full NR+1 steps.
//  T6 [AES_SEQ_ABORT_EN] abort_i at step 4 -> busy_o=0 next cycle, no done_o, data_o holds prior result.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: state, round counter and Rcon for 128/192/256-bit keys.
// Optional abort input enabled by defining AES_SEQ_ABORT_EN.
module aes_round_sequencer #(
  parameter int KEY_BITS = 128,
  parameter int DATA_W   = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                dec_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [KEY_BITS-1:0] key_i,
  output logic                rnd_go_o,
  input  logic                rnd_ack_i,
  output logic [DATA_W-1:0]   rnd_state_o,
  output logic [KEY_BITS-1:0] rnd_key_o,
  output logic [3:0]          round_o,
  output logic [7:0]          rcon_o,
  output logic                first_round_o,
  output logic                final_round_o,
  output logic                dec_o,
  input  logic [DATA_W-1:0]   rnd_result_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                busy_o,
`ifdef AES_SEQ_ABORT_EN
  input  logic                abort_i,
`endif
  output logic                done_o
);

  localparam int NR = KEY_BITS / 32 + 6;
  localparam logic [3:0] NR4 = 4'(NR);

  function automatic logic [7:0] xtime(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(
    input logic [7:0] x
  );
    logic [7:0] t;
    t = x ^ 8'h1B;
    return x[0] ? {1'b1, t[7:1]} : {1'b0, x[7:1]};
  endfunction

  function automatic logic [7:0] rcon_nth(
    input int n
  );
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < n; i++) r = xtime(r);
    return r;
  endfunction

  localparam logic [7:0] RCON_NR = rcon_nth(NR);

  if (DATA_W != 128) begin : g_dw_chk
    $error("aes_round_sequencer: DATA_W must be 128");
  end

  if (KEY_BITS != 128 && KEY_BITS != 192 &&
      KEY_BITS != 256) begin : g_kb_chk
    $error("aes_round_sequencer: bad KEY_BITS");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]          step_q;
  logic [7:0]          rcon_q;
  logic [7:0]          rcon_nx;
  logic [DATA_W-1:0]   blk_q;
  logic [DATA_W-1:0]   out_q;
  logic [KEY_BITS-1:0] key_q;
  logic                dec_q;
  logic                load_ok;
  logic                adv;
  logic                fin;
  logic                abort;
  logic                last;

`ifdef AES_SEQ_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign last = (step_q == NR4);

  always_comb begin
    state_d = state_q;
    load_ok = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_i) begin
          load_ok = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rnd_ack_i) begin
          adv = 1'b1;
          if (last) begin
            fin     = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Decrypt walks the Rcon chain backwards from Rcon[NR].
  always_comb begin
    rcon_nx = 8'h00;
    unique case (1'b1)
      (step_q == 4'd0) && !dec_q: rcon_nx = 8'h01;
      (step_q == 4'd0) &&  dec_q: rcon_nx = RCON_NR;
      (step_q != 4'd0) && !dec_q: rcon_nx = xtime(rcon_q);
      (step_q != 4'd0) &&  dec_q: rcon_nx = inv_xtime(rcon_q);
      default:                    rcon_nx = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      rcon_q  <= '0;
      blk_q   <= '0;
      out_q   <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_ok) begin
        blk_q  <= data_i;
        key_q  <= key_i;
        dec_q  <= dec_i;
        step_q <= '0;
        rcon_q <= '0;
      end
      if (adv) begin
        blk_q <= rnd_result_i;
      end
      if (adv && !fin) begin
        step_q <= step_q + 4'd1;
        rcon_q <= rcon_nx;
      end
      if (fin) begin
        out_q <= rnd_result_i;
      end
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign rnd_go_o      = (state_q == S_RUN);
  assign first_round_o = rnd_go_o && (step_q == 4'd0);
  assign final_round_o = rnd_go_o && last;
  assign round_o       = dec_q ? (NR4 - step_q) : step_q;
  assign rcon_o        = rcon_q;
  assign rnd_state_o   = blk_q;
  assign rnd_key_o     = key_q;
  assign dec_o         = dec_q;
  assign data_o        = out_q;

endmodule
